// File: rtl/regmux_n.sv
// Registered N-channel mux with a one-entry valid/ready output stage and auto-scan.
// Optional macro REGMUX_N_PARITY_EN adds a registered even-parity bit y_par.
module regmux_n #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NCH*WIDTH-1:0]  d,
    input  logic [SELW-1:0]       s,
    input  logic                  auto,
    input  logic                  load,
    input  logic                  y_ready,
    output logic [WIDTH-1:0]      y,
    output logic                  y_valid,
    output logic [SELW-1:0]       y_ch,
`ifdef REGMUX_N_PARITY_EN
    output logic                  y_par,
`endif
    output logic                  sel_err
);

    localparam logic [SELW:0]   NCH_W = NCH[SELW:0];
    localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

    logic [SELW-1:0]  scan_ptr;
    logic [SELW-1:0]  sel;
    logic             sel_ok;
    logic             cap;
    logic [WIDTH-1:0] data_sel;

    assign sel    = auto ? scan_ptr : s;
    assign sel_ok = ({1'b0, sel} < NCH_W);
    // y_ready reaches only this enable, never an output directly
    assign cap    = load & (~y_valid | y_ready);

    // Out-of-range selects fall through to zero data
    always_comb begin
        data_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) begin
                data_sel = d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y        <= '0;
            y_valid  <= 1'b0;
            y_ch     <= '0;
            sel_err  <= 1'b0;
            scan_ptr <= '0;
        end else if (cap) begin
            y       <= data_sel;
            y_ch    <= sel;
            y_valid <= 1'b1;
            if (!sel_ok) begin
                sel_err <= 1'b1;
            end
            if (auto) begin
                scan_ptr <= (scan_ptr == LAST) ? '0 : scan_ptr + SELW'(1);
            end
        end else if (y_valid && y_ready) begin
            y_valid <= 1'b0;
        end
    end

`ifdef REGMUX_N_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_par <= 1'b0;
        end else if (cap) begin
            y_par <= ^data_sel;
        end
    end
`endif

endmodule

// File: tb/tb_regmux_n.sv
// Self-checking bench for regmux_n: a 4-channel and a 3-channel instance share stimulus
// and are checked every cycle against a behavioural model, plus directed literal checks.
module tb_regmux_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] d = '0;
    logic [11:0] d3;
    logic [1:0]  s = '0;
    logic        auto_m = 1'b0;
    logic        load = 1'b0;
    logic        rdy = 1'b0;

    logic [3:0]  y4, y3;
    logic        yv4, yv3;
    logic [1:0]  ych4, ych3;
    logic        err4, err3;
`ifdef REGMUX_N_PARITY_EN
    logic        par4, par3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int my[2], mv[2], mch[2], merr[2], mptr[2];

    assign d3 = d[11:0];

    always #5 clk = ~clk;

    regmux_n #(.WIDTH(4), .NCH(4), .SELW(2)) dut4 (
        .clk(clk), .reset_n(rst_n), .d(d), .s(s), .auto(auto_m), .load(load),
        .y_ready(rdy), .y(y4), .y_valid(yv4), .y_ch(ych4),
`ifdef REGMUX_N_PARITY_EN
        .y_par(par4),
`endif
        .sel_err(err4)
    );

    regmux_n #(.WIDTH(4), .NCH(3), .SELW(2)) dut3 (
        .clk(clk), .reset_n(rst_n), .d(d3), .s(s), .auto(auto_m), .load(load),
        .y_ready(rdy), .y(y3), .y_valid(yv3), .y_ch(ych3),
`ifdef REGMUX_N_PARITY_EN
        .y_par(par3),
`endif
        .sel_err(err3)
    );

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int nch_of(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            my[i] = 0; mv[i] = 0; mch[i] = 0; merr[i] = 0; mptr[i] = 0;
        end
    endtask

    // One clock edge of the output stage, described by its rules
    task automatic model_step();
        int sel;
        for (int i = 0; i < 2; i++) begin
            sel = auto_m ? mptr[i] : int'(s);
            if (load && (mv[i] == 0 || rdy)) begin
                if (sel < nch_of(i)) begin
                    my[i] = int'(d >> (4 * sel)) & 15;
                end else begin
                    my[i]   = 0;
                    merr[i] = 1;
                end
                mch[i] = sel;
                mv[i]  = 1;
                if (auto_m) mptr[i] = (mptr[i] + 1) % nch_of(i);
            end else if (mv[i] == 1 && rdy) begin
                mv[i] = 0;
            end
        end
    endtask

    function automatic int parity(input int v);
        return ((v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1) + ((v >> 3) & 1)) % 2;
    endfunction

    task automatic compare_all();
        cmp("y4", int'(y4), my[0]);
        cmp("y_valid4", int'(yv4), mv[0]);
        cmp("y_ch4", int'(ych4), mch[0]);
        cmp("sel_err4", int'(err4), merr[0]);
        cmp("y3", int'(y3), my[1]);
        cmp("y_valid3", int'(yv3), mv[1]);
        cmp("y_ch3", int'(ych3), mch[1]);
        cmp("sel_err3", int'(err3), merr[1]);
`ifdef REGMUX_N_PARITY_EN
        cmp("y_par4", int'(par4), parity(my[0]));
        cmp("y_par3", int'(par3), parity(my[1]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a falling edge: pulse reset low well inside the cycle
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        cmp("rst_y", int'(y4), 0);
        cmp("rst_valid", int'(yv4), 0);
        rst_n = 1'b1;

        // manual select, no backpressure
        d = 16'h3C5A; auto_m = 0; load = 1; rdy = 1;
        s = 2'd0; tick(); cmp("man_y0", int'(y4), 4'b1010); cmp("man_ch0", int'(ych4), 0);
        s = 2'd1; tick(); cmp("man_y1", int'(y4), 4'b0101); cmp("man_ch1", int'(ych4), 1);
        s = 2'd2; tick(); cmp("man_y2", int'(y4), 4'b1100); cmp("man_v2", int'(yv4), 1);
        s = 2'd3; tick(); cmp("man_y3", int'(y4), 4'b0011); cmp("man_ch3", int'(ych4), 3);

        // auto scan with wrap, then idle, then resume at ch2
        auto_m = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            cmp("auto_ch", int'(ych4), k % 4);
        end
        load = 0;
        tick(); cmp("idle_valid", int'(yv4), 0);
        tick();
        load = 1;
        tick(); cmp("resume_ch", int'(ych4), 2); cmp("resume_y", int'(y4), 4'b1100);

        // backpressure
        auto_m = 0; s = 2'd1;
        tick(); cmp("bp_cap", int'(y4), 4'b0101);
        rdy = 0; s = 2'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp("bp_hold_y", int'(y4), 4'b0101);
            cmp("bp_hold_v", int'(yv4), 1);
        end
        rdy = 1;
        tick(); cmp("bp_rel_y", int'(y4), 4'b1100); cmp("bp_rel_v", int'(yv4), 1);

        // drain
        load = 0;
        tick(); cmp("drain_v", int'(yv4), 0); cmp("drain_y", int'(y4), 4'b1100);

        // out-of-range select on the 3-channel instance
        load = 1; s = 2'd3;
        tick();
        cmp("oor_y", int'(y3), 0); cmp("oor_ch", int'(ych3), 3); cmp("oor_err", int'(err3), 1);
`ifdef REGMUX_N_PARITY_EN
        cmp("oor_par", int'(par3), 0);
`endif
        s = 2'd1;
        tick(); cmp("oor_sticky", int'(err3), 1); cmp("oor_next_y", int'(y3), 4'b0101);

        // bring scan_ptr to 2 on the 4-channel instance, then reset mid-cycle
        auto_m = 1;
        repeat (3) tick();
        cmp("pre_rst_ch", int'(ych4), 1);
        async_reset();
        cmp("arst_y", int'(y4), 0); cmp("arst_v", int'(yv4), 0);
        cmp("arst_ch", int'(ych4), 0); cmp("arst_err", int'(err3), 0);
        tick(); cmp("post_rst_ch", int'(ych4), 0); cmp("post_rst_y", int'(y4), 4'b1010);

`ifdef REGMUX_N_PARITY_EN
        auto_m = 0; s = 2'd0; d = 16'h0007;
        tick(); cmp("par_0111", int'(par4), 1);
`endif

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            d      = 16'($urandom);
            s      = 2'($urandom_range(0, 3));
            auto_m = ($urandom_range(0, 3) == 0);
            load   = ($urandom_range(0, 3) != 0);
            rdy    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 60) == 0) async_reset();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regmux_n.md
# regmux_n

Registered, parametrised N-channel multiplexer with a valid/ready output stage and an optional auto-scan mode that steps through channels on its own. It is the clocked, multi-channel successor to the team's combinational 2:1 mux. It sits between several same-width data sources and a single downstream consumer that can apply backpressure.

## Interface
- `WIDTH`, default 4: data width per channel.
- `NCH`, default 4: number of channels. Range 2..16.
- `SELW`, default 2: select width, `$clog2(NCH)`.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `d`, input, `NCH*WIDTH`: packed channel data. Channel k is `d[k*WIDTH +: WIDTH]`.
- `s`, input, `SELW`: manual channel select.
- `auto`, input, 1: 1 = auto-scan mode, 0 = manual mode.
- `load`, input, 1: capture request.
- `y_ready`, input, 1: downstream accepts `y`.
- `y`, output, `WIDTH`: registered selected data.
- `y_valid`, output, 1: `y` holds unconsumed data.
- `y_ch`, output, `SELW`: channel index of the current `y`.
- `sel_err`, output, 1: sticky flag for an out-of-range manual select.

## Operation
- **Reset values.** One-entry output register. `y` = 0, `y_valid` = 0, `y_ch` = 0, `sel_err` = 0, internal `scan_ptr` = 0.
- **Effective select.** `sel = auto ? scan_ptr : s`.
- **Capture condition.** `cap = load & (~y_valid | y_ready)`.
- **On cap.** `y` <= `d[sel]`, `y_ch` <= `sel`, `y_valid` <= 1.
- **Consume.** If `y_valid & y_ready & ~cap`, then `y_valid` <= 0. `y` and `y_ch` keep their values.
- **Stall.** If `y_valid & ~y_ready`, then `y`, `y_ch` and `y_valid` hold, and `load` is ignored. The source must keep `load` asserted to retry; nothing is queued.
- **Simultaneous consume and load.** `y_valid & y_ready & load` replaces the data in the same cycle. `y_valid` stays 1 and there is no bubble.
- **Auto-scan pointer.**
  - `scan_ptr` advances only on a cap cycle while `auto` = 1.
  - It advances from `NCH-1` back to 0.
  - In manual mode `scan_ptr` holds its value. Switching mode does not reset it.
- **Out-of-range manual select.** Applies when `s >= NCH`, which is possible only when NCH is not a power of 2.
  - A cap in that case loads `y` = 0 and `y_ch` = `s`, and sets `sel_err` = 1.
  - `sel_err` clears only on reset.
  - `auto` mode never produces out-of-range selects.
- **Mid-operation reset.** Asserting `reset_n` low clears all state immediately, regardless of the clock. Any pending `y` is dropped.

## Timing
- Latency: data sampled at edge n appears on `y` after edge n. That is 1 cycle from `load` to `y_valid`.
- Throughput: 1 capture per cycle while `y_ready` = 1.
- `y` is glitch-free, driven directly from flops. There is no combinational path from `d` or `s` to `y`.
- There is one combinational path, from `y_ready` to the capture enable. It is internal only; no output depends combinationally on an input.
- Reset release is synchronous to `clk` at the consumer's side. The first capture can occur on the first edge with `reset_n` = 1.

## Configuration
- Macro: `REGMUX_N_PARITY_EN`.
- **Defined.**
  - Adds output `y_par` (1 bit) = even parity of `y`. It is registered with `y` on every cap and reset to 0.
  - An out-of-range capture stores `y_par` = 0.
- **Undefined.** The port and its flop are absent, and behaviour is otherwise identical.

## Test plan
- **Manual select, no backpressure.** NCH=4, WIDTH=4, `d` = {0011, 1100, 0101, 1010} (ch3..ch0), `y_ready` = 1, `load` = 1. Step `s` through 0,1,2,3 on consecutive cycles. Required: `y` = 1010, 0101, 1100, 0011, each one cycle later, with `y_valid` high throughout and `y_ch` matching `s`.
- **Auto scan with wrap.**
  - Stimulus: `auto` = 1, `load` = 1, `y_ready` = 1 for 6 cycles.
  - Required `y_ch` sequence: 0,1,2,3,0,1.
  - Then deassert `load` for 2 cycles. Required: `scan_ptr` holds, and the next capture is ch2.
- **Backpressure.**
  - Stimulus: capture ch1 (0101), then `y_ready` = 0 for 3 cycles while `load` = 1 and `s` = 2.
  - Required: `y` stays 0101 and `y_valid` stays 1.
  - Then `y_ready` = 1. Required: `y` = 1100 on the next edge with no bubble.
- **Drain.** With `y_valid` = 1, drive `load` = 0 and `y_ready` = 1. Required: `y_valid` = 0 on the next edge, and `y` still shows the last data.
- **Out-of-range select.** NCH=3 (SELW=2), `s` = 3, `load` = 1. Required: `y` = 0, `y_ch` = 3, `sel_err` = 1. `sel_err` stays 1 after later valid selects.
- **Asynchronous reset.** Pulse `reset_n` low mid-cycle while `y_valid` = 1 and `auto` = 1 with `scan_ptr` = 2. Required: all outputs go to 0 immediately, and the first auto capture after release is ch0. With `REGMUX_N_PARITY_EN`, `y` = 0111 must give `y_par` = 1.
